// File: rtl/spi_frame_controller.sv
// rtl/spi_frame_controller.sv - frame sequencer for the ingress SPI shift register
// Drives enable/clear, captures and parity-checks each frame, hands it off via a one-entry holding register.
module spi_frame_controller #(
  parameter int FRAME_BITS = 25,
  parameter int DEST_W     = 2,
  parameter int CNT_W      = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           select,
  input  logic                           shift_load,
  input  logic [FRAME_BITS-1:0]          shift_data,
  output logic                           shift_enable,
  output logic                           shift_clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DEST_W-1:0]              out_dest,
  output logic [FRAME_BITS-DEST_W-2:0]   out_payload,
  output logic                           parity_err,
  output logic                           overrun,
  output logic [CNT_W-1:0]               abort_cnt,
  output logic [CNT_W-1:0]               perr_cnt,
  output logic [CNT_W-1:0]               ovr_cnt
);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, CLEAR, WAIT_DESEL} state_t;

  state_t                  state, state_d;
  logic [FRAME_BITS-1:0]   frame_q;
  logic                    enable_d;
  logic                    capture;
  logic                    hold_load;
  logic                    abort_d;
  logic                    perr_d;
  logic                    ovr_d;

  always_comb begin
    state_d   = state;
    enable_d  = shift_enable;
    capture   = 1'b0;
    hold_load = 1'b0;
    abort_d   = 1'b0;
    perr_d    = 1'b0;
    ovr_d     = 1'b0;
    case (state)
      IDLE: begin
        enable_d = 1'b0;
        if (select) begin
          state_d  = SHIFT;
          enable_d = 1'b1;
        end
      end
      SHIFT: begin
        // a completed frame wins over a deselect in the same cycle
        if (shift_load) begin
          capture  = 1'b1;
          enable_d = 1'b0;
          state_d  = CHECK;
        end else if (!select) begin
          abort_d  = 1'b1;
          enable_d = 1'b0;
          state_d  = CLEAR;
        end
      end
      CHECK: begin
        state_d = CLEAR;
        if (^frame_q) begin
          perr_d = 1'b1;
        end else if (!out_valid || out_ready) begin
          hold_load = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d = select ? WAIT_DESEL : IDLE;
      end
      WAIT_DESEL: begin
        if (!select) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shift_enable <= 1'b0;
      shift_clear  <= 1'b0;
      parity_err   <= 1'b0;
      overrun      <= 1'b0;
      frame_q      <= '0;
    end else begin
      state        <= state_d;
      shift_enable <= enable_d;
      shift_clear  <= (state_d == CLEAR);
      parity_err   <= perr_d;
      overrun      <= ovr_d;
      if (capture) frame_q <= shift_data;
    end
  end

  // holding register runs independently so a frame can wait while the next one shifts in
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_dest    <= '0;
      out_payload <= '0;
    end else if (hold_load) begin
      out_valid   <= 1'b1;
      out_dest    <= frame_q[FRAME_BITS-1 -: DEST_W];
      out_payload <= frame_q[FRAME_BITS-DEST_W-1:1];
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      abort_cnt <= '0;
      perr_cnt  <= '0;
      ovr_cnt   <= '0;
    end else begin
      if (abort_d && (abort_cnt != '1)) abort_cnt <= abort_cnt + 1'b1;
      if (perr_d  && (perr_cnt  != '1)) perr_cnt  <= perr_cnt  + 1'b1;
      if (ovr_d   && (ovr_cnt   != '1)) ovr_cnt   <= ovr_cnt   + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_frame_controller.sv
// tb/tb_spi_frame_controller.sv - scoreboard bench for spi_frame_controller with a shift register model
module tb_spi_frame_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        select = 1'b0;
  logic        sdi = 1'b0;
  logic        shift_load;
  logic [24:0] shift_data;
  logic        shift_enable, shift_clear, out_valid, parity_err, overrun;
  logic        out_ready = 1'b0;
  logic [1:0]  out_dest;
  logic [21:0] out_payload;
  logic [7:0]  abort_cnt, perr_cnt, ovr_cnt;

  int checks = 0;
  int errors = 0;
  int perr_pulses, ovr_pulses, clr_pulses, valid_cycles, delivered;
  logic [23:0] exp_q[$];

  always #5 clock = ~clock;

  spi_frame_controller dut (
    .clock(clock), .reset(reset), .select(select),
    .shift_load(shift_load), .shift_data(shift_data),
    .shift_enable(shift_enable), .shift_clear(shift_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dest(out_dest), .out_payload(out_payload),
    .parity_err(parity_err), .overrun(overrun),
    .abort_cnt(abort_cnt), .perr_cnt(perr_cnt), .ovr_cnt(ovr_cnt)
  );

  // 25-bit SPI receive shift register: MSB first, load once 25 bits are stored
  logic [24:0] sr;
  logic [4:0]  sr_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sr <= '0; sr_cnt <= '0;
    end else if (shift_clear) begin
      sr <= '0; sr_cnt <= '0;
    end else if (shift_enable) begin
      sr <= {sr[23:0], sdi};
      if (sr_cnt < 5'd31) sr_cnt <= sr_cnt + 5'd1;
    end
  end
  assign shift_data = sr;
  assign shift_load = (sr_cnt >= 5'd25);

  always @(negedge clock) begin
    if (!reset) begin
      if (parity_err)  perr_pulses++;
      if (overrun)     ovr_pulses++;
      if (shift_clear) clr_pulses++;
      if (out_valid)   valid_cycles++;
      if (out_valid && out_ready) begin
        delivered++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL delivery: got unexpected frame %h, required none", {out_dest, out_payload});
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if ({out_dest, out_payload} !== e) begin
            errors++;
            $display("FAIL delivery: got %h, required %h", {out_dest, out_payload}, e);
          end
        end
      end
    end
  end

  function automatic logic [24:0] mk(input logic [1:0] d, input logic [21:0] p, input bit bad);
    return {d, p, (^{d, p}) ^ bad};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_stats();
    perr_pulses = 0; ovr_pulses = 0; clr_pulses = 0; valid_cycles = 0; delivered = 0;
  endtask

  // must start with the FSM idle; returns 1 time unit after the last data edge
  task automatic send_bits(input logic [24:0] f, input int nbits, input bit hold);
    select = 1'b1;
    tick(1);
    for (int i = 0; i < nbits; i++) begin
      sdi = f[24-i];
      tick(1);
    end
    if (!hold) select = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({shift_enable, shift_clear, out_valid, parity_err, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {shift_enable, shift_clear, out_valid, parity_err, overrun});
    end
    checks++;
    if ({abort_cnt, perr_cnt, ovr_cnt, out_dest, out_payload} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", {abort_cnt, perr_cnt, ovr_cnt, out_dest, out_payload});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_good_frame();
    logic [24:0] f;
    f = mk(2'b10, 22'h155555, 1'b0);
    clear_stats();
    out_ready = 1'b1;
    exp_q.push_back(f[24:1]);
    send_bits(f, 25, 1'b0);
    tick(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL good_latency_early: out_valid=%b, required 0", out_valid);
    end
    tick(1);
    checks++;
    if ({out_valid, shift_clear} !== 2'b11) begin
      errors++; $display("FAIL good_latency: valid,clear=%b, required 11", {out_valid, shift_clear});
    end
    tick(5);
    checks++;
    if ({delivered, valid_cycles, clr_pulses} !== {32'd1, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL good_counts: delivered=%0d valid=%0d clear=%0d, required 1 1 1",
               delivered, valid_cycles, clr_pulses);
    end
    checks++;
    if ({abort_cnt, perr_cnt, ovr_cnt} !== 24'h0) begin
      errors++; $display("FAIL good_err_cnts: got %h, required 0", {abort_cnt, perr_cnt, ovr_cnt});
    end
  endtask

  task automatic test_parity();
    clear_stats();
    out_ready = 1'b1;
    send_bits(mk(2'b10, 22'h155555, 1'b1), 25, 1'b0);
    tick(6);
    checks++;
    if ({perr_pulses, valid_cycles, clr_pulses} !== {32'd1, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL parity_pulses: perr=%0d valid=%0d clear=%0d, required 1 0 1",
               perr_pulses, valid_cycles, clr_pulses);
    end
    checks++;
    if (perr_cnt !== 8'd1) begin
      errors++; $display("FAIL parity_cnt: got %0d, required 1", perr_cnt);
    end
  endtask

  task automatic test_abort();
    logic [24:0] f;
    clear_stats();
    out_ready = 1'b1;
    send_bits(mk(2'b01, 22'h2aaaaa, 1'b0), 10, 1'b0);
    tick(4);
    checks++;
    if ({abort_cnt, 24'(clr_pulses), 24'(valid_cycles)} !== {8'd1, 24'd1, 24'd0}) begin
      errors++;
      $display("FAIL abort: cnt=%0d clear=%0d valid=%0d, required 1 1 0", abort_cnt, clr_pulses, valid_cycles);
    end
    f = mk(2'b11, 22'h0f0f0f, 1'b0);
    exp_q.push_back(f[24:1]);
    send_bits(f, 25, 1'b0);
    tick(6);
    checks++;
    if (delivered !== 1) begin
      errors++; $display("FAIL abort_next: delivered=%0d, required 1", delivered);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] f1, f2;
    clear_stats();
    out_ready = 1'b0;
    f1 = mk(2'b00, 22'h123456, 1'b0);
    f2 = mk(2'b01, 22'h3abcde, 1'b0);
    exp_q.push_back(f1[24:1]);
    send_bits(f1, 25, 1'b0);
    tick(3);
    send_bits(f2, 25, 1'b0);
    tick(5);
    checks++;
    if ({ovr_cnt, 24'(ovr_pulses)} !== {8'd1, 24'd1}) begin
      errors++; $display("FAIL overrun: cnt=%0d pulses=%0d, required 1 1", ovr_cnt, ovr_pulses);
    end
    checks++;
    if ({out_valid, out_dest, out_payload} !== {1'b1, f1[24:1]}) begin
      errors++;
      $display("FAIL hold_stable: got %h, required %h", {out_valid, out_dest, out_payload}, {1'b1, f1[24:1]});
    end
    out_ready = 1'b1;
    tick(4);
    checks++;
    if ({32'(delivered), 32'(exp_q.size()), 1'(out_valid)} !== {32'd1, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_drain: delivered=%0d queued=%0d valid=%b, required 1 0 0",
               delivered, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_long_select();
    logic [24:0] f;
    clear_stats();
    out_ready = 1'b1;
    f = mk(2'b10, 22'h00ff00, 1'b0);
    exp_q.push_back(f[24:1]);
    send_bits(f, 25, 1'b1);
    for (int i = 0; i < 50; i++) begin
      sdi = 1'($urandom_range(0, 1));
      tick(1);
    end
    checks++;
    if ({shift_enable, 8'(clr_pulses), 8'(delivered)} !== {1'b0, 8'd1, 8'd1}) begin
      errors++;
      $display("FAIL long_select: enable=%b clear=%0d delivered=%0d, required 0 1 1",
               shift_enable, clr_pulses, delivered);
    end
    select = 1'b0;
    tick(3);
    f = mk(2'b01, 22'h1c3c3c, 1'b0);
    exp_q.push_back(f[24:1]);
    send_bits(f, 25, 1'b0);
    tick(6);
    checks++;
    if (delivered !== 2) begin
      errors++; $display("FAIL long_select_next: delivered=%0d, required 2", delivered);
    end
  endtask

  task automatic test_reset_midframe();
    logic [24:0] f;
    clear_stats();
    out_ready = 1'b0;
    f = mk(2'b11, 22'h2468ac, 1'b0);
    exp_q.push_back(f[24:1]);
    send_bits(f, 25, 1'b0);
    tick(4);
    send_bits(mk(2'b00, 22'h111111, 1'b0), 12, 1'b1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({shift_enable, shift_clear, out_valid, abort_cnt, perr_cnt, ovr_cnt} !== 27'h0) begin
      errors++;
      $display("FAIL reset_async: enable=%b clear=%b valid=%b cnts=%h, required all 0",
               shift_enable, shift_clear, out_valid, {abort_cnt, perr_cnt, ovr_cnt});
    end
    exp_q.delete();
    select = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    tick(2);
    clear_stats();
    out_ready = 1'b1;
    f = mk(2'b10, 22'h35a5a5, 1'b0);
    exp_q.push_back(f[24:1]);
    send_bits(f, 25, 1'b0);
    tick(6);
    checks++;
    if (delivered !== 1) begin
      errors++; $display("FAIL reset_recover: delivered=%0d, required 1", delivered);
    end
    for (int i = 0; i < 256; i++) begin
      select = 1'b1;
      tick(1);
      select = 1'b0;
      tick(4);
    end
    checks++;
    if (abort_cnt !== 8'd255) begin
      errors++; $display("FAIL abort_saturate: got %0d, required 255", abort_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_abort();
    test_back_to_back();
    test_long_select();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: %0d frames undelivered, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
